// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv_pkg
// Brief  : Shared RISC-V fetch definitions: opcodes, immediates, queue entry.
// Rev    : 1.0
// ============================================================================
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // One in-flight prediction: the direction guessed and the PC to resume at
  // if that guess turns out wrong.
  typedef struct packed {
    logic            pred_taken;
    logic [XLEN-1:0] alt_pc;
  } pred_entry_t;

  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/br_pred_queue.sv
`default_nettype none
// ============================================================================
// Module : br_pred_queue
// Brief  : Circular FIFO of in-flight branch predictions, combinational head.
// Rev    : 1.0
// ============================================================================
module br_pred_queue
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  pred_entry_t push_entry,
  input  logic        pop,
  output pred_entry_t head_entry,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  pred_entry_t   mem_q [DEPTH];
  pred_entry_t   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign head_entry = mem_q[rd_ptr_q];

  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_pc_unit
// Brief  : IF-stage next-PC generator with branch/JAL predecode and repair.
// Rev    : 1.0
// ============================================================================
module fetch_pc_unit
  import rv_pkg::*;
#(
  parameter int                PC_WIDTH = XLEN,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h4000_0000,
  parameter int                DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [31:0]         inst_if,
  input  logic                br_pred_taken,
  output logic [PC_WIDTH-1:0] pc_if,
  output logic                is_br_if,
  output logic [PC_WIDTH-1:0] pc_next,
  input  logic                resolve_valid,
  input  logic                resolve_taken,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                flush,
  output logic                queue_full,
  output logic                queue_err,
  output logic [31:0]         pred_count,
  output logic [31:0]         mispred_count
);

  logic [PC_WIDTH-1:0] pc_if_q, pc_if_d;
  logic                queue_err_q, queue_err_d;
  logic [31:0]         pred_count_q, pred_count_d;
  logic [31:0]         mispred_count_q, mispred_count_d;

  logic                is_jal;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] b_target;
  logic [PC_WIDTH-1:0] j_target;
  logic                q_full;
  logic                q_empty;
  pred_entry_t         head_entry;
  pred_entry_t         push_entry;
  logic                pop;
  logic                push;
  logic                mispredict;
  logic                full_hold;

  assign is_br_if = (inst_if[6:0] == OPC_BRANCH);
  assign is_jal   = (inst_if[6:0] == OPC_JAL);
  assign pc_plus4 = pc_if_q + PC_WIDTH'(4);
  assign b_target = pc_if_q + PC_WIDTH'($signed(b_imm(inst_if)));
  assign j_target = pc_if_q + PC_WIDTH'($signed(j_imm(inst_if)));

  assign pop        = resolve_valid & ~q_empty;
  assign mispredict = pop & (head_entry.pred_taken != resolve_taken);
  assign flush      = redirect_valid | mispredict;
  // A new branch with no free slot must wait at its own PC until the head retires.
  assign full_hold  = q_full & is_br_if & ~pop;
  assign push       = is_br_if & ~stall & ~flush & (~q_full | pop);

  always_comb begin
    push_entry            = '0;
    push_entry.pred_taken = br_pred_taken;
    push_entry.alt_pc     = XLEN'(br_pred_taken ? pc_plus4 : b_target);
  end

  always_comb begin
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (mispredict) begin
      pc_next = head_entry.alt_pc[PC_WIDTH-1:0];
    end else if (stall | full_hold) begin
      pc_next = pc_if_q;
    end else if (is_jal) begin
      pc_next = j_target;
    end else if (is_br_if & br_pred_taken) begin
      pc_next = b_target;
    end else begin
      pc_next = pc_plus4;
    end
  end

  always_comb begin
    pc_if_d         = pc_next;
    queue_err_d     = queue_err_q | (resolve_valid & q_empty);
    pred_count_d    = pred_count_q;
    mispred_count_d = mispred_count_q;
    if (push && (pred_count_q != 32'hFFFF_FFFF)) begin
      pred_count_d = pred_count_q + 32'd1;
    end
    if (mispredict && (mispred_count_q != 32'hFFFF_FFFF)) begin
      mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_if_q         <= RESET_PC;
      queue_err_q     <= 1'b0;
      pred_count_q    <= '0;
      mispred_count_q <= '0;
    end else begin
      pc_if_q         <= pc_if_d;
      queue_err_q     <= queue_err_d;
      pred_count_q    <= pred_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  br_pred_queue #(
    .DEPTH (DEPTH)
  ) u_pred_queue (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign pc_if         = pc_if_q;
  assign queue_full    = q_full;
  assign queue_err     = queue_err_q;
  assign pred_count    = pred_count_q;
  assign mispred_count = mispred_count_q;

endmodule
`default_nettype wire
